decode_queue: RTL
=================

Name: decode_queue

Overview:
Parametrised decode stage for the rv5stage core, placed between fetch and execute. A QDEPTH-entry instruction buffer decouples fetch from decode using a valid/ready handshake. The instruction at the buffer head is decoded to RV32I control, register indices and immediates into a registered output. A LOAD_LAT-deep scoreboard detects load-use hazards against several downstream stages and inserts the required number of bubbles.

Parameters:
QDEPTH, 4, instruction buffer entries; power of two, minimum 2
LOAD_LAT, 1, cycles after issue during which a load result cannot be forwarded; minimum 1, maximum 4
CNTW, $clog2(QDEPTH+1), occupancy counter width (derived; not to be overridden)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
flush  in  1  pipeline flush
stall  in  1  downstream hold; output registers and scoreboard freeze
in_valid  in  1  fetch offers an instruction
in_ready  out  1  buffer can accept; equals !full && !flush
in_pc  in  32  fetched PC
in_inst  in  32  fetched instruction word
out_valid  out  1  registered decoded instruction valid
out_pc  out  32  PC of decoded instruction
out_opcode  out  7  inst[6:0]
out_rd / out_rs1 / out_rs2  out  5 each  inst[11:7] / inst[19:15] / inst[24:20]
out_funct3  out  3  inst[14:12]
out_funct7  out  7  inst[31:25]
out_imm  out  32  selected sign-extended immediate
out_ctrl  out  12  bit order [11:0] = rd_valid, rs1_valid, rs2_valid, reg_write, alu_src, lo_imm, pcrel, branch, uncond, mem_read, mem_write, mem_to_reg
out_error  out  1  decoded instruction has an illegal opcode
hazard  out  1  combinational; the head instruction is blocked by the scoreboard this cycle
occupancy  out  CNTW  buffer entry count

Behaviour:
- Priority: rst > flush > stall > hazard > normal.
- Reset and flush: buffer emptied (occupancy=0), all scoreboard entries invalid, and every out_* register cleared to 0, including out_valid and out_error.
- During flush, a push is dropped even if in_valid=1.
- Push: when in_valid && in_ready, {in_pc, in_inst} is written at the tail pointer. Pointers wrap modulo QDEPTH.
- Full buffer: in_ready=0 when occupancy==QDEPTH. A push and pop in the same cycle is legal only when not full; occupancy is then unchanged.
- Decode, combinational on the head entry (opcode -> immediate; ctrl bits in out_ctrl order):
  - 0010011 I-arith -> imm_i; 110111000000
  - 0110011 R-arith -> imm_i; 111100000000
  - 0000011 load -> imm_i; 110111000101
  - 0100011 store -> imm_s; 011010000010
  - 1100011 branch -> imm_b; 011000110000
  - 0110111 LUI -> imm_u; 100111000000
  - 0010111 AUIPC -> imm_u; 100111100000
  - 1101111 JAL -> imm_j; 100110111000
  - 1100111 JALR -> imm_i; 110110011000
  - any other opcode -> ctrl=0, imm=0, error=1
- Immediate formats: imm_i, imm_s, imm_b, imm_u and imm_j follow standard RV32I sign extension; imm_b and imm_j have bit 0 = 0.
- Scoreboard: LOAD_LAT entries {v, rd}.
  - On every cycle with !stall, entry 0 <= {issued && mem_to_reg && rd!=0, rd}, and entry i <= entry i-1.
  - Entry 0 corresponds to the instruction currently held in the out_* registers.
- Hazard: asserted when the buffer is non-empty, an entry is valid, and the head's rs1 (with rs1_valid) or rs2 (with rs2_valid) is non-zero and equals that entry's rd.
- Issue: when !stall && !flush.
  - If the buffer is non-empty and there is no hazard: the head is popped, and the out_* registers load the decode with out_valid=1.
  - Otherwise (empty buffer or hazard): the out_* registers load a bubble (all 0) and nothing is popped.
- Stall: the out_* registers, the scoreboard and the read pointer hold. Pushes continue while !full.
- Latency: an instruction pushed into an empty buffer with no stall or hazard appears on out_valid on the next clock edge.
- Illegal opcode: issued normally with out_valid=1, out_error=1, ctrl=0. It never creates a scoreboard entry.
- A load-use pair with LOAD_LAT=L produces exactly L bubbles when nothing intervenes; each intervening independent instruction reduces the bubble count by one.

Test Plan:
- Reset, then push 0x00500093 (addi x1,x0,5) at pc=0x100 -> next cycle: out_valid=1, out_rd=1, out_imm=5, out_ctrl=0xDC0; in the reset cycle all outputs are 0.
- LOAD_LAT=1: lw x2,0(x1) then add x3,x2,x2 -> exactly one cycle with out_valid=0 and hazard=1, then add issues. Repeat with LOAD_LAT=3 -> three bubbles.
- Load into x0 followed by add x3,x0,x0 -> no hazard and no bubble.
- Hold stall=1 and push QDEPTH instructions -> in_ready=0 and occupancy==QDEPTH. Release stall -> instructions issue in FIFO order, wrap-around is correct, and in_ready rises.
- Assert flush with 3 entries buffered and a load in the scoreboard -> next cycle: occupancy=0, out_valid=0, all scoreboard entries invalid, and a dependent instruction pushed afterwards issues without a bubble.
- Push 0xFFFFFFFF -> out_valid=1, out_error=1, out_ctrl=0; the pipeline continues with the following instruction.

Source files
------------

// File: rtl/decode_queue.sv
// Decode stage: a small instruction FIFO decouples fetch from decode. The head
// entry is decoded into registered outputs, and a load scoreboard inserts load-use bubbles.
module decode_queue #(
    parameter int QDEPTH   = 4,
    parameter int LOAD_LAT = 1,
    parameter int CNTW     = $clog2(QDEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            stall,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_pc,
    input  logic [31:0]     in_inst,
    output logic            out_valid,
    output logic [31:0]     out_pc,
    output logic [6:0]      out_opcode,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [31:0]     out_imm,
    output logic [11:0]     out_ctrl,
    output logic            out_error,
    output logic            hazard,
    output logic [CNTW-1:0] occupancy
);
    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

    logic [31:0]     pc_mem   [QDEPTH];
    logic [31:0]     inst_mem [QDEPTH];
    logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [CNTW-1:0] count_reg;

    logic            empty, full, push, pop, issue;
    logic [31:0]     head_pc, head_inst;
    logic [11:0]     dec_ctrl;
    logic [31:0]     dec_imm;
    logic            dec_err;
    logic [4:0]      head_rd, head_rs1, head_rs2;

    logic [LOAD_LAT-1:0] sb_v_reg;
    logic [4:0]          sb_rd_reg [LOAD_LAT];
    logic [LOAD_LAT-1:0] sb_match;

    assign empty     = (count_reg == '0);
    assign full      = (count_reg == CNTW'(QDEPTH));
    assign in_ready  = !full && !flush;
    assign push      = in_valid && in_ready && !rst;
    assign issue     = !stall && !flush;
    assign pop       = issue && !empty && !hazard;
    assign occupancy = count_reg;

    assign head_pc   = pc_mem[rd_ptr_reg];
    assign head_inst = inst_mem[rd_ptr_reg];
    assign head_rd   = head_inst[11:7];
    assign head_rs1  = head_inst[19:15];
    assign head_rs2  = head_inst[24:20];

    // Buffer storage carries no reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_reg]   <= in_pc;
            inst_mem[wr_ptr_reg] <= in_inst;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_reg + CNTW'(push) - CNTW'(pop);
        end
    end

    always_comb begin
        dec_ctrl = '0;
        dec_imm  = '0;
        dec_err  = 1'b0;
        case (head_inst[6:0])
            7'b0010011: begin dec_ctrl = 12'b110111000000; dec_imm = {{20{head_inst[31]}}, head_inst[31:20]}; end
            7'b0110011: begin dec_ctrl = 12'b111100000000; dec_imm = {{20{head_inst[31]}}, head_inst[31:20]}; end
            7'b0000011: begin dec_ctrl = 12'b110111000101; dec_imm = {{20{head_inst[31]}}, head_inst[31:20]}; end
            7'b0100011: begin
                dec_ctrl = 12'b011010000010;
                dec_imm  = {{20{head_inst[31]}}, head_inst[31:25], head_inst[11:7]};
            end
            7'b1100011: begin
                dec_ctrl = 12'b011000110000;
                dec_imm  = {{19{head_inst[31]}}, head_inst[31], head_inst[7],
                            head_inst[30:25], head_inst[11:8], 1'b0};
            end
            7'b0110111: begin dec_ctrl = 12'b100111000000; dec_imm = {head_inst[31:12], 12'b0}; end
            7'b0010111: begin dec_ctrl = 12'b100111100000; dec_imm = {head_inst[31:12], 12'b0}; end
            7'b1101111: begin
                dec_ctrl = 12'b100110111000;
                dec_imm  = {{11{head_inst[31]}}, head_inst[31], head_inst[19:12],
                            head_inst[20], head_inst[30:21], 1'b0};
            end
            7'b1100111: begin dec_ctrl = 12'b110110011000; dec_imm = {{20{head_inst[31]}}, head_inst[31:20]}; end
            default:    dec_err = 1'b1;
        endcase
    end

    // Entry 0 tracks whatever sits in the output registers; older loads shift upward.
    generate
        for (genvar gi = 0; gi < LOAD_LAT; gi++) begin : g_sb
            assign sb_match[gi] = sb_v_reg[gi] &&
                ((dec_ctrl[10] && head_rs1 != 5'd0 && head_rs1 == sb_rd_reg[gi]) ||
                 (dec_ctrl[9]  && head_rs2 != 5'd0 && head_rs2 == sb_rd_reg[gi]));

            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    sb_v_reg[gi]  <= 1'b0;
                    sb_rd_reg[gi] <= '0;
                end else if (!stall) begin
                    if (gi == 0) begin
                        sb_v_reg[gi]  <= pop && dec_ctrl[0] && head_rd != 5'd0;
                        sb_rd_reg[gi] <= pop ? head_rd : 5'd0;
                    end else begin
                        sb_v_reg[gi]  <= sb_v_reg[(gi > 0) ? gi - 1 : 0];
                        sb_rd_reg[gi] <= sb_rd_reg[(gi > 0) ? gi - 1 : 0];
                    end
                end
            end
        end
    endgenerate

    assign hazard = !empty && (|sb_match);

    always_ff @(posedge clk) begin
        if (rst || flush || (issue && !pop)) begin
            out_valid  <= 1'b0;
            out_pc     <= '0;
            out_opcode <= '0;
            out_rd     <= '0;
            out_rs1    <= '0;
            out_rs2    <= '0;
            out_funct3 <= '0;
            out_funct7 <= '0;
            out_imm    <= '0;
            out_ctrl   <= '0;
            out_error  <= 1'b0;
        end else if (pop) begin
            out_valid  <= 1'b1;
            out_pc     <= head_pc;
            out_opcode <= head_inst[6:0];
            out_rd     <= head_rd;
            out_rs1    <= head_rs1;
            out_rs2    <= head_rs2;
            out_funct3 <= head_inst[14:12];
            out_funct7 <= head_inst[31:25];
            out_imm    <= dec_imm;
            out_ctrl   <= dec_ctrl;
            out_error  <= dec_err;
        end
    end
endmodule
